// File: rtl/lc3_ctrl_pkg.sv
// LC3 control-unit package: microsequencer state encoding, opcodes and the
// select encodings shared between the control FSM and the datapath.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    StFetchMar = 5'd0,
    StFetchMdr = 5'd1,
    StFetchIr  = 5'd2,
    StDecode   = 5'd3,
    StAlu      = 5'd4,
    StBr       = 5'd5,
    StJmp      = 5'd6,
    StJsr      = 5'd7,
    StLea      = 5'd8,
    StAddr     = 5'd9,
    StRd       = 5'd10,
    StInd      = 5'd11,
    StWb       = 5'd12,
    StSdata    = 5'd13,
    StSwr      = 5'd14,
    StTrap1    = 5'd15,
    StTrap2    = 5'd16,
    StTrap3    = 5'd17,
    StHalt     = 5'd18
  } state_e;

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpRti  = 4'b1000;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpRsv  = 4'b1101;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAnd  = 2'b01;
  localparam logic [1:0] AluAdd  = 2'b10;
  localparam logic [1:0] AluNot  = 2'b11;

  localparam logic [1:0] A2mSext11 = 2'd0;
  localparam logic [1:0] A2mSext9  = 2'd1;
  localparam logic [1:0] A2mSext6  = 2'd2;
  localparam logic [1:0] A2mZero   = 2'd3;

  localparam logic [1:0] PcmuxBus   = 2'd0;
  localparam logic [1:0] PcmuxAdder = 2'd1;
  localparam logic [1:0] PcmuxInc   = 2'd2;

  localparam logic MarmuxZext  = 1'b0;
  localparam logic MarmuxAdder = 1'b1;

  // Opcodes whose data phase goes through a memory read.
  function automatic logic needs_read(input logic [3:0] op);
    return (op == OpLd) || (op == OpLdr) || (op == OpLdi) || (op == OpSti);
  endfunction

endpackage

// File: rtl/lc3_control.sv
// LC3 microsequencer: fetch / decode / execute, one control word per cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ir, cc             datapath IR and {N,Z,P}
//   ld_*               register load strobes
//   gate_*             bus drivers (at most one high per cycle)
//   dr, sr1, sr2       register file selects
//   aluk               ALU operation
//   a1m_sel, a2m_sel   address adder operand selects
//   pcmux_sel          PC source
//   marmux_sel         MAR mux source
//   mem_en             MDR source is memory (else bus)
//   mem_rw             memory write strobe
//   halted             machine stopped in HALT
//   state              current state, for debug
module lc3_control
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  cc,
  output logic        ld_ir,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_cc,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        gate_alu,
  output logic        gate_pc,
  output logic        gate_marmux,
  output logic        gate_mdr,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [1:0]  aluk,
  output logic        a1m_sel,
  output logic [1:0]  a2m_sel,
  output logic [1:0]  pcmux_sel,
  output logic        marmux_sel,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        halted,
  output logic [4:0]  state
);

  localparam logic [7:0] WaitInit = 8'(MEM_RD_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ben_q, ben_d;
  logic       ind_q, ind_d;   // LDI/STI pointer already followed
  logic [7:0] wait_q, wait_d;

  logic [3:0] op;
  logic       rd_state;
  logic       rd_done;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign state     = state_q;
  assign unused_ir = ^ir[5:3];

  assign rd_state = (state_q == StFetchMdr) || (state_q == StRd) || (state_q == StTrap2);
  assign rd_done  = (wait_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetchMar;
      ben_q   <= 1'b0;
      ind_q   <= 1'b0;
      wait_q  <= WaitInit;
    end else begin
      state_q <= state_d;
      ben_q   <= ben_d;
      ind_q   <= ind_d;
      wait_q  <= wait_d;
    end
  end

  // Next state and sequencing bookkeeping.
  always_comb begin
    state_d = state_q;
    ben_d   = ben_q;
    ind_d   = ind_q;
    // Counter reloads whenever we are not waiting on memory.
    wait_d  = WaitInit;
    if (rd_state && !rd_done) begin
      wait_d = wait_q - 8'd1;
    end

    unique case (state_q)
      StFetchMar: begin
        state_d = StFetchMdr;
        ind_d   = 1'b0;
      end
      StFetchMdr: if (rd_done) state_d = StFetchIr;
      StFetchIr:  state_d = StDecode;
      StDecode: begin
        ben_d = (ir[11] & cc[2]) | (ir[10] & cc[1]) | (ir[9] & cc[0]);
        case (op)
          OpAdd, OpAnd, OpNot:                     state_d = StAlu;
          OpBr:                                    state_d = StBr;
          OpJmp:                                   state_d = StJmp;
          OpJsr:                                   state_d = StJsr;
          OpLea:                                   state_d = StLea;
          OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti:  state_d = StAddr;
          OpTrap:                                  state_d = StTrap1;
          default:                                 state_d = StHalt;  // RTI, reserved
        endcase
      end
      StAddr: state_d = needs_read(op) ? StRd : StSdata;
      StRd: begin
        if (rd_done) begin
          if ((op == OpLdi || op == OpSti) && !ind_q) state_d = StInd;
          else if (op == OpSti)                       state_d = StSdata;
          else                                        state_d = StWb;
        end
      end
      StInd: begin
        state_d = StRd;
        ind_d   = 1'b1;
      end
      StSdata: state_d = StSwr;
      StTrap1: state_d = StTrap2;
      StTrap2: if (rd_done) state_d = StTrap3;
      StHalt:  state_d = StHalt;
      default: state_d = StFetchMar;  // single-cycle execute states
    endcase
  end

  // Control word: Moore on state plus IR fields, all zero during reset.
  always_comb begin
    ld_ir       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_cc       = 1'b0;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    gate_alu    = 1'b0;
    gate_pc     = 1'b0;
    gate_marmux = 1'b0;
    gate_mdr    = 1'b0;
    dr          = 3'd0;
    sr1         = 3'd0;
    sr2         = 3'd0;
    aluk        = AluPass;
    a1m_sel     = 1'b0;
    a2m_sel     = A2mSext11;
    pcmux_sel   = PcmuxBus;
    marmux_sel  = MarmuxZext;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    halted      = 1'b0;

    if (!rst) begin
      unique case (state_q)
        StFetchMar: begin
          gate_pc   = 1'b1;
          ld_mar    = 1'b1;
          ld_pc     = 1'b1;
          pcmux_sel = PcmuxInc;
        end
        StFetchMdr, StRd: begin
          mem_en = 1'b1;
          ld_mdr = 1'b1;
        end
        StFetchIr: begin
          gate_mdr = 1'b1;
          ld_ir    = 1'b1;
        end
        StAlu: begin
          sr1      = ir[8:6];
          sr2      = ir[2:0];
          dr       = ir[11:9];
          gate_alu = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          aluk     = (op == OpAdd) ? AluAdd : (op == OpAnd) ? AluAnd : AluNot;
        end
        StBr: begin
          if (ben_q) begin
            ld_pc     = 1'b1;
            pcmux_sel = PcmuxAdder;
            a1m_sel   = 1'b1;
            a2m_sel   = A2mSext9;
          end
        end
        StJmp: begin
          sr1       = ir[8:6];
          a2m_sel   = A2mZero;
          pcmux_sel = PcmuxAdder;
          ld_pc     = 1'b1;
        end
        StJsr: begin
          gate_pc   = 1'b1;
          ld_reg    = 1'b1;
          dr        = 3'd7;
          ld_pc     = 1'b1;
          pcmux_sel = PcmuxAdder;
          if (ir[11]) begin
            a1m_sel = 1'b1;
            a2m_sel = A2mSext11;
          end else begin
            sr1     = ir[8:6];
            a2m_sel = A2mZero;
          end
        end
        StLea: begin
          gate_marmux = 1'b1;
          marmux_sel  = MarmuxAdder;
          a1m_sel     = 1'b1;
          a2m_sel     = A2mSext9;
          dr          = ir[11:9];
          ld_reg      = 1'b1;
        end
        StAddr: begin
          ld_mar      = 1'b1;
          gate_marmux = 1'b1;
          marmux_sel  = MarmuxAdder;
          if (op == OpLdr || op == OpStr) begin
            sr1     = ir[8:6];
            a2m_sel = A2mSext6;
          end else begin
            a1m_sel = 1'b1;
            a2m_sel = A2mSext9;
          end
        end
        StInd: begin
          gate_mdr = 1'b1;
          ld_mar   = 1'b1;
        end
        StWb: begin
          gate_mdr = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          dr       = ir[11:9];
        end
        StSdata: begin
          sr1      = ir[11:9];
          aluk     = AluPass;
          gate_alu = 1'b1;
          ld_mdr   = 1'b1;
        end
        StSwr: mem_rw = 1'b1;
        StTrap1: begin
          gate_marmux = 1'b1;
          marmux_sel  = MarmuxZext;
          ld_mar      = 1'b1;
        end
        // Return address goes to R7 here so only one bus driver is active per cycle.
        StTrap2: begin
          gate_pc = 1'b1;
          ld_reg  = 1'b1;
          dr      = 3'd7;
          mem_en  = 1'b1;
          ld_mdr  = 1'b1;
        end
        StTrap3: begin
          gate_mdr  = 1'b1;
          pcmux_sel = PcmuxBus;
          ld_pc     = 1'b1;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: two instances (1 and 3 read cycles) share a
// behavioural LC3 datapath; the selected one drives it while the other is held
// in reset.
module tb_lc3_control;
  import lc3_ctrl_pkg::*;

  typedef struct packed {
    logic       ld_ir, ld_reg, ld_pc, ld_cc, ld_mar, ld_mdr;
    logic       gate_alu, gate_pc, gate_marmux, gate_mdr;
    logic [2:0] dr, sr1, sr2;
    logic [1:0] aluk;
    logic       a1m;
    logic [1:0] a2m, pcmux;
    logic       marmux, mem_en, mem_rw, halted;
    logic [4:0] state;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [1:0]  rst_v;
  ctl_t        ctl [2];
  ctl_t        c;

  // Datapath model state
  logic [15:0] mem [65536];
  logic [15:0] regs [8];
  logic [15:0] pc, ir, mar, mdr;
  logic [2:0]  cc;
  logic [15:0] bus, sr1v, sr2v, aluv, a1v, a2v, addr, marv, pcv;

  // Model write port used for setup while the DUT is in reset
  logic        poke_en;
  logic [1:0]  poke_kind;
  logic [15:0] poke_a, poke_d;

  int n_total = 0;
  int n_pass  = 0;
  int rw_cnt  = 0;
  int stb_cnt = 0;

  always #5 clk = ~clk;

  assign rst_v[0] = rst | sel;
  assign rst_v[1] = rst | ~sel;
  assign c        = ctl[sel];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lc3_control #(.MEM_RD_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .ir         (ir),
      .cc         (cc),
      .ld_ir      (ctl[g].ld_ir),
      .ld_reg     (ctl[g].ld_reg),
      .ld_pc      (ctl[g].ld_pc),
      .ld_cc      (ctl[g].ld_cc),
      .ld_mar     (ctl[g].ld_mar),
      .ld_mdr     (ctl[g].ld_mdr),
      .gate_alu   (ctl[g].gate_alu),
      .gate_pc    (ctl[g].gate_pc),
      .gate_marmux(ctl[g].gate_marmux),
      .gate_mdr   (ctl[g].gate_mdr),
      .dr         (ctl[g].dr),
      .sr1        (ctl[g].sr1),
      .sr2        (ctl[g].sr2),
      .aluk       (ctl[g].aluk),
      .a1m_sel    (ctl[g].a1m),
      .a2m_sel    (ctl[g].a2m),
      .pcmux_sel  (ctl[g].pcmux),
      .marmux_sel (ctl[g].marmux),
      .mem_en     (ctl[g].mem_en),
      .mem_rw     (ctl[g].mem_rw),
      .halted     (ctl[g].halted),
      .state      (ctl[g].state)
    );
  end

  always_comb begin
    sr1v = regs[c.sr1];
    sr2v = ir[5] ? {{11{ir[4]}}, ir[4:0]} : regs[c.sr2];
    case (c.aluk)
      2'b10:   aluv = sr1v + sr2v;
      2'b01:   aluv = sr1v & sr2v;
      2'b11:   aluv = ~sr1v;
      default: aluv = sr1v;
    endcase
    a1v = c.a1m ? pc : sr1v;
    case (c.a2m)
      2'd0:    a2v = {{5{ir[10]}}, ir[10:0]};
      2'd1:    a2v = {{7{ir[8]}}, ir[8:0]};
      2'd2:    a2v = {{10{ir[5]}}, ir[5:0]};
      default: a2v = 16'h0000;
    endcase
    addr = a1v + a2v;
    marv = c.marmux ? addr : {8'h00, ir[7:0]};
    bus  = 16'h0000;
    if (c.gate_pc)          bus = pc;
    else if (c.gate_mdr)    bus = mdr;
    else if (c.gate_alu)    bus = aluv;
    else if (c.gate_marmux) bus = marv;
    case (c.pcmux)
      2'd0:    pcv = bus;
      2'd1:    pcv = addr;
      default: pcv = pc + 16'd1;
    endcase
  end

  always @(posedge clk) begin
    if (poke_en) begin
      case (poke_kind)
        2'd0: mem[poke_a] <= poke_d;
        2'd1: regs[poke_a[2:0]] <= poke_d;
        2'd2: pc <= poke_d;
        default: cc <= poke_d[2:0];
      endcase
    end else begin
      if (c.ld_ir)  ir <= bus;
      if (c.ld_pc)  pc <= pcv;
      if (c.ld_reg) regs[c.dr] <= bus;
      if (c.ld_cc)  cc <= bus[15] ? 3'b100 : (bus == 16'h0000) ? 3'b010 : 3'b001;
      if (c.ld_mar) mar <= bus;
      if (c.ld_mdr) mdr <= c.mem_en ? mem[mar] : bus;
      if (c.mem_rw) mem[mar] <= mdr;
    end
  end

  // Per-cycle monitor: single bus driver, write-strobe and strobe activity counts.
  always @(negedge clk) begin
    if (!rst) begin
      n_total++;
      assert ($countones({c.gate_alu, c.gate_pc, c.gate_marmux, c.gate_mdr}) <= 1) n_pass++;
      else $error("FAIL gate_onehot: got %b required at most one high",
                  {c.gate_alu, c.gate_pc, c.gate_marmux, c.gate_mdr});
      if (c.mem_rw) rw_cnt++;
      if (c.ld_ir | c.ld_reg | c.ld_pc | c.ld_cc | c.ld_mar | c.ld_mdr | c.gate_alu |
          c.gate_pc | c.gate_marmux | c.gate_mdr | c.mem_en | c.mem_rw) stb_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_kind = kind;
    poke_a    = a;
    poke_d    = d;
    tick();
    poke_en   = 1'b0;
  endtask

  // Runs one instruction from FETCH_MAR back to FETCH_MAR, bounded.
  task automatic run_instr(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (c.state != 5'(StFetchMar) && cyc < 100);
  endtask

  task automatic reset_to(input logic [15:0] new_pc);
    rst = 1'b1;
    poke(2'd2, 16'h0000, new_pc);
    rst = 1'b0;
  endtask

  task automatic suite(input int e);
    int cyc;
    int base;
    rst = 1'b1;
    tick();
    poke(2'd0, 16'h3000, 16'h1261);  // ADD R1,R1,#1
    poke(2'd0, 16'h3001, 16'h05FE);  // BRz #-2
    poke(2'd0, 16'h3004, 16'hA400);  // LDI R2,#0
    poke(2'd0, 16'h3005, 16'h4000);
    poke(2'd0, 16'h4000, 16'h8001);
    poke(2'd0, 16'h3006, 16'h773F);  // STR R3,R4,#-1
    poke(2'd0, 16'h4FFF, 16'h0000);
    poke(2'd0, 16'h3010, 16'hF025);  // TRAP x25
    poke(2'd0, 16'h0025, 16'h0400);
    poke(2'd0, 16'h0400, 16'hD000);  // reserved opcode
    poke(2'd0, 16'h0401, 16'h1261);  // ADD R1,R1,#1
    poke(2'd0, 16'h0402, 16'h4810);  // JSR #+16
    poke(2'd1, 16'h0001, 16'h0004);
    poke(2'd1, 16'h0003, 16'hBEEF);
    poke(2'd1, 16'h0004, 16'h5000);
    poke(2'd3, 16'h0000, 16'h0002);
    poke(2'd2, 16'h0000, 16'h3000);
    chk("rst_state", 32'(c.state), 32'(StFetchMar));
    chk("rst_ctl", 32'(c >> 5), 32'h0);

    rst = 1'b0;
    run_instr(cyc);
    chk("add_cycles", cyc, 5 + e);
    chk("add_r1", regs[1], 16'h0005);
    chk("add_cc", cc, 3'b001);
    chk("add_pc", pc, 16'h3001);

    run_instr(cyc);
    chk("brnt_cycles", cyc, 5 + e);
    chk("brnt_pc", pc, 16'h3002);

    rst = 1'b1;
    poke(2'd3, 16'h0000, 16'h0002);
    reset_to(16'h3001);
    run_instr(cyc);
    chk("brt_cycles", cyc, 5 + e);
    chk("brt_pc", pc, 16'h3000);

    reset_to(16'h3004);
    base = rw_cnt;
    run_instr(cyc);
    chk("ldi_cycles", cyc, 9 + 3 * e);
    chk("ldi_r2", regs[2], 16'h8001);
    chk("ldi_cc", cc, 3'b100);
    chk("ldi_no_write", rw_cnt - base, 0);
    chk("ldi_pc", pc, 16'h3005);

    reset_to(16'h3006);
    base = rw_cnt;
    run_instr(cyc);
    chk("str_cycles", cyc, 7 + e);
    chk("str_mem", mem[16'h4FFF], 16'hBEEF);
    chk("str_one_write", rw_cnt - base, 1);

    reset_to(16'h3010);
    run_instr(cyc);
    chk("trap_cycles", cyc, 7 + 2 * e);
    chk("trap_r7", regs[7], 16'h3011);
    chk("trap_pc", pc, 16'h0400);

    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!c.halted && cyc < 30);
    chk("halt_latency", cyc, 4 + e);
    base = stb_cnt;
    repeat (20) tick();
    chk("halt_held", c.halted, 1'b1);
    chk("halt_no_strobes", stb_cnt - base, 0);
    chk("halt_pc", pc, 16'h0401);

    rst = 1'b1;
    tick();
    chk("rst_unhalt", c.halted, 1'b0);
    rst = 1'b0;
    run_instr(cyc);
    chk("resume_cycles", cyc, 5 + e);
    chk("resume_r1", regs[1], 16'h0006);
    run_instr(cyc);
    chk("jsr_cycles", cyc, 5 + e);
    chk("jsr_r7", regs[7], 16'h0403);
    chk("jsr_pc", pc, 16'h0413);
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    poke_en   = 1'b0;
    poke_kind = 2'd0;
    poke_a    = 16'h0000;
    poke_d    = 16'h0000;
    tick();
    suite(0);
    rst = 1'b1;
    sel = 1'b1;
    tick();
    suite(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
